// File: rtl/mem_bilo_pp_pkg.sv
// Shared constants, read FSM encoding and helpers for the
// block-in / line-out ping-pong buffer.
package mem_bilo_pp_pkg;

  localparam int ENC_PIXEL_WIDTH = 8;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN
  } rd_state_e;

  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_bilo_pp_if.sv
// Block writer / line reader bundle for mem_bilo_pp.
// master drives blocks and read starts, slave is the buffer.
interface mem_bilo_pp_if
  import mem_bilo_pp_pkg::*;
#(
  parameter int PIXEL_WIDTH = ENC_PIXEL_WIDTH,
  parameter int BLK_W       = 32,
  parameter int BLK_H       = 32
);
  localparam int XW = log2(BLK_W / 4);
  localparam int YW = log2(BLK_H / 4);
  localparam int LW = log2(BLK_H);

  logic                     wen_i;
  logic [XW-1:0]            wx_i;
  logic [YW-1:0]            wy_i;
  logic [PIXEL_WIDTH*16-1:0] wdata_i;
  logic                     wdone_i;
  logic                     wfull_o;
  logic                     werr_o;
  logic                     rstart_i;
  logic                     rempty_o;
  logic                     rbusy_o;
  logic                     rvalid_o;
  logic [LW-1:0]            rline_o;
  logic                     rlast_o;
  logic [PIXEL_WIDTH*BLK_W-1:0] rdata_o;

  modport master (
    output wen_i, wx_i, wy_i, wdata_i, wdone_i, rstart_i,
    input  wfull_o, werr_o, rempty_o, rbusy_o,
    input  rvalid_o, rline_o, rlast_o, rdata_o
  );

  modport slave (
    input  wen_i, wx_i, wy_i, wdata_i, wdone_i, rstart_i,
    output wfull_o, werr_o, rempty_o, rbusy_o,
    output rvalid_o, rline_o, rlast_o, rdata_o
  );
endinterface

// File: rtl/mem_bilo_pp_ram_2p_param.sv
// Generic two-port RAM: one write port, one read port,
// registered read data (1-cycle latency).
module ram_2p_param #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_bilo_pp.sv
// Ping-pong buffer: 4x4 blocks in any order per page,
// committed pages streamed out one pixel row per cycle.
module mem_bilo_pp
  import mem_bilo_pp_pkg::*;
#(
  parameter int PIXEL_WIDTH = ENC_PIXEL_WIDTH,
  parameter int BLK_W       = 32,
  parameter int BLK_H       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bilo_pp_if.slave  bus
);
  localparam int NB = BLK_W / 4;
  localparam int XW = log2(NB);
  localparam int YW = log2(BLK_H / 4);
  localparam int LW = log2(BLK_H);
  localparam int AW = LW + 1;
  localparam int DW = PIXEL_WIDTH * 4;

  rd_state_e     state_q, state_d;
  logic [LW-1:0] row_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_pg_q, rd_pg_q;
  logic          wfull_q, rempty_q, werr_q;
  logic          rvalid_q, rlast_q;
  logic [LW-1:0] rline_q;
  logic          issue, busy, go;
  logic          wr_ok, commit, rel;
  logic [DW-1:0] bank_q [NB];
  logic [PIXEL_WIDTH*BLK_W-1:0] rd;

  assign wr_ok  = bus.wen_i & ~wfull_q;
  assign commit = bus.wdone_i & ~wfull_q;
  assign rel    = rvalid_q & rlast_q;

  always_comb begin
    cnt_d = cnt_q;
    if (commit & ~rel)      cnt_d = cnt_q + 2'd1;
    else if (rel & ~commit) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_pg_q  <= 1'b0;
      rd_pg_q  <= 1'b0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      werr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_pg_q  <= wr_pg_q ^ commit;
      rd_pg_q  <= rd_pg_q ^ rel;
      wfull_q  <= (cnt_d == 2'd2);
      rempty_q <= (cnt_d == 2'd0);
      werr_q   <= werr_q
                | ((bus.wen_i | bus.wdone_i) & wfull_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == RD_READ):
        if (row_q == LW'(BLK_H - 1)) state_d = RD_DRAIN;
      (state_q == RD_DRAIN):
        state_d = RD_IDLE;
      default:
        if (go) state_d = RD_READ;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    go    = 1'b0;
    unique case (1'b1)
      (state_q == RD_READ): begin
        issue = 1'b1;
        busy  = 1'b1;
      end
      (state_q == RD_DRAIN):
        busy = 1'b1;
      default:
        go = bus.rstart_i & ~rempty_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      rvalid_q <= 1'b0;
      rline_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      if (go)         row_q <= '0;
      else if (issue) row_q <= row_q + 1'b1;
      rvalid_q <= issue;
      rline_q  <= row_q;
      rlast_q  <= issue & (row_q == LW'(BLK_H - 1));
    end
  end

  // Block row r of column x lives in bank (x + r) mod NB.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [XW-1:0] diff;
    logic          we;
    logic [DW-1:0] wd;

    assign diff = XW'(b) - bus.wx_i;
    assign we   = wr_ok & ((diff >> 2) == '0);

    always_comb begin
      wd = bus.wdata_i[3*DW +: DW];
      unique case (diff[1:0])
        2'd1:    wd = bus.wdata_i[2*DW +: DW];
        2'd2:    wd = bus.wdata_i[DW +: DW];
        2'd3:    wd = bus.wdata_i[0 +: DW];
        default: wd = bus.wdata_i[3*DW +: DW];
      endcase
    end

    ram_2p_param #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr ({wr_pg_q, bus.wy_i, diff[1:0]}),
      .wdata (wd),
      .raddr ({rd_pg_q, row_q}),
      .rdata (bank_q[b])
    );
  end

  always_comb begin
    rd = '0;
    if (rvalid_q)
      for (int s = 0; s < NB; s++)
        rd[(NB-1-s)*DW +: DW] =
          bank_q[XW'(s + int'(rline_q[1:0]))];
  end

  assign bus.wfull_o  = wfull_q;
  assign bus.werr_o   = werr_q;
  assign bus.rempty_o = rempty_q;
  assign bus.rbusy_o  = busy;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rline_o  = rline_q;
  assign bus.rlast_o  = rlast_q;
  assign bus.rdata_o  = rd;
endmodule

// File: tb/tb_mem_bilo_pp.sv
// Directed bench for mem_bilo_pp: block fills in several
// orders, ping-pong status, overlap release and reset abort.
module tb_mem_bilo_pp;
  localparam int PW = 8;
  localparam int BW = 32;
  localparam int BH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_bilo_pp_if #(.PIXEL_WIDTH(PW), .BLK_W(BW), .BLK_H(BH)) bus ();

  mem_bilo_pp #(.PIXEL_WIDTH(PW), .BLK_W(BW), .BLK_H(BH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit wen;
    bit wdone;
    bit rstart;
    bit e_full;
    bit e_empty;
    bit e_err;
    bit e_busy;
  } vec_t;

  function automatic void chk(string nm, logic [255:0] act,
                              logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] pix(int seed, int r, int c);
    if (seed == 0) return 8'((r << 5) | c);
    return 8'((r * 37) ^ (c * 5) ^ seed);
  endfunction

  function automatic logic [127:0] blk(int seed, int bx, int by);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        v[(15 - (r*4 + j))*8 +: 8] = pix(seed, by*4 + r, bx*4 + j);
    return v;
  endfunction

  function automatic logic [255:0] row_exp(int seed, int r);
    logic [255:0] v;
    for (int c = 0; c < BW; c++)
      v[(BW - 1 - c)*8 +: 8] = pix(seed, r, c);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(int seed, int mode, bit commit);
    int ord[64];
    int j, t;
    for (int i = 0; i < 64; i++)
      ord[i] = (mode == 1) ? 63 - i : i;
    if (mode == 2)
      for (int i = 63; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    for (int i = 0; i < 64; i++) begin
      bus.wen_i   = 1'b1;
      bus.wx_i    = 3'(ord[i] % 8);
      bus.wy_i    = 3'(ord[i] / 8);
      bus.wdata_i = blk(seed, ord[i] % 8, ord[i] / 8);
      bus.wdone_i = commit && (i == 63);
      tick();
    end
    bus.wen_i   = 1'b0;
    bus.wdone_i = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rempty"}, bus.rempty_o, 1);
    chk({tag, "_wfull"},  bus.wfull_o, 0);
    chk({tag, "_werr"},   bus.werr_o, 0);
    chk({tag, "_rbusy"},  bus.rbusy_o, 0);
    chk({tag, "_rvalid"}, bus.rvalid_o, 0);
    chk({tag, "_rlast"},  bus.rlast_o, 0);
    chk({tag, "_rline"},  bus.rline_o, 0);
    chk({tag, "_rdata"},  bus.rdata_o, 0);
  endtask

  task automatic read_page(int seed, bit commit_last, int mid_start,
                           int abort_row, bit exp_empty);
    bus.rstart_i = 1'b1;
    tick();
    bus.rstart_i = 1'b0;
    chk("start_busy", bus.rbusy_o, 1);
    chk("start_novalid", bus.rvalid_o, 0);
    for (int i = 0; i < BH; i++) begin
      if (i == mid_start) bus.rstart_i = 1'b1;
      if (i == abort_row) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      tick();
      bus.rstart_i = 1'b0;
      chk($sformatf("rvalid%0d", i), bus.rvalid_o, 1);
      chk($sformatf("rline%0d", i), bus.rline_o, i);
      chk($sformatf("rlast%0d", i), bus.rlast_o, i == BH - 1);
      chk($sformatf("rdata_s%0d_r%0d", seed, i), bus.rdata_o,
          row_exp(seed, i));
      if (i == BH - 1 && commit_last) bus.wdone_i = 1'b1;
    end
    tick();
    bus.wdone_i = 1'b0;
    chk("end_rvalid", bus.rvalid_o, 0);
    chk("end_rbusy", bus.rbusy_o, 0);
    chk("end_rempty", bus.rempty_o, exp_empty);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{wen:0, wdone:1, rstart:0,
              e_full:1, e_empty:0, e_err:0, e_busy:0};
    vt[1] = '{wen:1, wdone:0, rstart:0,
              e_full:1, e_empty:0, e_err:1, e_busy:0};
    vt[2] = '{wen:0, wdone:1, rstart:0,
              e_full:1, e_empty:0, e_err:1, e_busy:0};
    vt[3] = '{wen:0, wdone:0, rstart:0,
              e_full:1, e_empty:0, e_err:1, e_busy:0};

    bus.wen_i = 1'b0;
    bus.wx_i = '0;
    bus.wy_i = '0;
    bus.wdata_i = '0;
    bus.wdone_i = 1'b0;
    bus.rstart_i = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // raster fill, commit on the last write
    fill(0, 0, 1);
    chk("s1_rempty", bus.rempty_o, 0);
    chk("s1_wfull", bus.wfull_o, 0);
    read_page(0, 0, -1, -1, 1);

    // reverse and shuffled orders
    fill(0, 1, 1);
    read_page(0, 0, -1, -1, 1);
    fill(0, 2, 1);
    read_page(0, 0, -1, -1, 1);

    // two pages committed, writes while full dropped
    fill(1, 0, 1);
    chk("s3_wfull0", bus.wfull_o, 0);
    fill(2, 2, 0);
    for (int k = 0; k < 4; k++) begin
      bus.wen_i    = vt[k].wen;
      bus.wdone_i  = vt[k].wdone;
      bus.rstart_i = vt[k].rstart;
      bus.wx_i     = '0;
      bus.wy_i     = '0;
      bus.wdata_i  = '1;
      tick();
      bus.wen_i    = 1'b0;
      bus.wdone_i  = 1'b0;
      bus.rstart_i = 1'b0;
      chk($sformatf("vec%0d_wfull", k), bus.wfull_o, vt[k].e_full);
      chk($sformatf("vec%0d_rempty", k), bus.rempty_o, vt[k].e_empty);
      chk($sformatf("vec%0d_werr", k), bus.werr_o, vt[k].e_err);
      chk($sformatf("vec%0d_rbusy", k), bus.rbusy_o, vt[k].e_busy);
    end
    read_page(1, 0, -1, -1, 0);
    chk("s3_wfull_rel", bus.wfull_o, 0);
    read_page(2, 0, -1, -1, 1);

    // commit coincides with release
    fill(3, 0, 1);
    fill(4, 2, 0);
    read_page(3, 1, -1, -1, 0);
    chk("s4_wfull", bus.wfull_o, 0);
    read_page(4, 0, -1, -1, 1);

    // start while empty, start mid-read
    bus.rstart_i = 1'b1;
    tick();
    bus.rstart_i = 1'b0;
    chk("s5_empty_busy", bus.rbusy_o, 0);
    tick();
    chk("s5_empty_valid", bus.rvalid_o, 0);
    fill(5, 0, 1);
    read_page(5, 0, 10, -1, 1);
    tick();
    chk("s5_no_extra", bus.rvalid_o, 0);

    // reset in the middle of a stream, then recover
    fill(6, 1, 1);
    read_page(6, 0, -1, 10, 1);
    chk("s6_post_rempty", bus.rempty_o, 1);
    chk("s6_post_werr", bus.werr_o, 0);
    fill(7, 2, 1);
    read_page(7, 0, -1, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
